// File: rtl/spi_leds_pkg.sv
// Shared types and constants for the LED/button SPI master.
package spi_leds_pkg;

    localparam int unsigned SPI_LEDS_BITS = 8;
    localparam logic [3:0]  SPI_LEDS_SIG  = 4'hA;
    localparam int unsigned CNT_W         = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOW  = 3'd1,
        ST_HIGH = 3'd2,
        ST_HOLD = 3'd3,
        ST_DONE = 3'd4,
        ST_GAP  = 3'd5
    } state_e;

endpackage

// File: rtl/spi_leds_clk_div.sv
// SCK half-period timer: one-cycle tick every CLK_DIV cycles while enabled,
// restarting from zero whenever the enable rises.
module spi_leds_clk_div
    import spi_leds_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    output logic tick_c_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick_c_o = en_i && (cnt_q == CNT_W'(CLK_DIV - 1));
        cnt_d    = '0;
        if (en_i && !tick_c_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_leds_master.sv
// SPI mode-0 master for the LED/button slave: one 8-bit full-duplex transfer per start.
// Define SPI_LEDS_MASTER_SIG_CHECK_EN to add sig_err_o (returned signature nibble check).
module spi_leds_master
    import spi_leds_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned GAP     = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     start_i,
    input  logic [SPI_LEDS_BITS-1:0] tx_data_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [SPI_LEDS_BITS-1:0] rx_data_o,
`ifdef SPI_LEDS_MASTER_SIG_CHECK_EN
    output logic                     sig_err_o,
`endif
    output logic                     spi_sck_o,
    output logic                     spi_mosi_o,
    input  logic                     spi_miso_i,
    output logic                     spi_cs_o
);

    localparam int unsigned BIT_W = $clog2(SPI_LEDS_BITS);
    localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    state_e                   state_q, state_d;
    logic [SPI_LEDS_BITS-1:0] tx_q, tx_d;
    logic [SPI_LEDS_BITS-1:0] rx_sh_q, rx_sh_d;
    logic [SPI_LEDS_BITS-1:0] rx_q, rx_d;
    logic [BIT_W-1:0]         bit_q, bit_d;
    logic [GAP_W-1:0]         gap_q, gap_d;
    logic                     cs_q, cs_d;
    logic                     sck_q, sck_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     div_en;
    logic                     tick;
`ifdef SPI_LEDS_MASTER_SIG_CHECK_EN
    logic                     sig_q, sig_d;
`endif

    assign div_en = (state_q == ST_LOW) || (state_q == ST_HIGH) || (state_q == ST_HOLD);

    spi_leds_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .en_i     (div_en),
        .tick_c_o (tick)
    );

    // Next state; output registers are derived from the next state so they align with it.
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_sh_d = rx_sh_q;
        rx_d    = rx_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
`ifdef SPI_LEDS_MASTER_SIG_CHECK_EN
        sig_d   = sig_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    tx_d    = tx_data_i;
                    bit_d   = '0;
                    state_d = ST_LOW;
                end
            end
            ST_LOW: begin
                if (tick) begin
                    rx_sh_d = {rx_sh_q[SPI_LEDS_BITS-2:0], spi_miso_i};
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (tick) begin
                    bit_d = bit_q + BIT_W'(1);
                    if (bit_q == BIT_W'(SPI_LEDS_BITS - 1)) begin
                        state_d = ST_HOLD;
                    end else begin
                        tx_d    = {tx_q[SPI_LEDS_BITS-2:0], 1'b0};
                        state_d = ST_LOW;
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    rx_d    = rx_sh_q;
                    tx_d    = '0;
                    gap_d   = '0;
`ifdef SPI_LEDS_MASTER_SIG_CHECK_EN
                    sig_d   = (rx_sh_q[SPI_LEDS_BITS-1 -: 4] != SPI_LEDS_SIG);
`endif
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (gap_q == GAP_W'(GAP - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cs_d   = !((state_d == ST_LOW) || (state_d == ST_HIGH) || (state_d == ST_HOLD));
        sck_d  = (state_d == ST_HIGH);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            tx_q    <= '0;
            rx_sh_q <= '0;
            rx_q    <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            cs_q    <= 1'b1;
            sck_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_sh_q <= rx_sh_d;
            rx_q    <= rx_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            cs_q    <= cs_d;
            sck_q   <= sck_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef SPI_LEDS_MASTER_SIG_CHECK_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_err_o = sig_q;
`endif

    // MOSI comes straight from the shift register MSB, which is itself a flop.
    assign spi_mosi_o = tx_q[SPI_LEDS_BITS-1];
    assign spi_sck_o  = sck_q;
    assign spi_cs_o   = cs_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign rx_data_o  = rx_q;

endmodule

// File: tb/tb_spi_leds_master.sv
// Randomised scoreboard bench for spi_leds_master with a behavioural SPI slave.
module tb_spi_leds_master;

    localparam int unsigned CD   = 4;
    localparam int unsigned GP   = 4;
    localparam int unsigned CD2  = 2;
    localparam int unsigned XFER = 17 * CD;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] rx;
        logic       sig;
        int         done_cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] tx_data;
    logic       busy, done, sck, mosi, cs;
    logic       miso;
    logic [7:0] rx_data;
    logic       sig_err;

    logic       start2, busy2, done2, sck2, mosi2, cs2, miso2;
    logic [7:0] tx2, rx2;
    logic       sig2;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_done = 0;
    int   n_exp = 0;
    int   rises = 0;
    int   rise_total = 0;
    int   last_done = 0;
    int   b2b_base = 0;
    bit   b2b = 1'b0;
    logic cs_prev = 1'b1;
    logic [7:0] mosi_sh = '0;
    logic [7:0] slv_sh = '0;
    exp_t exp_q[$];
    logic [7:0] slave_q[$];

    int   rises2 = 0;
    int   last_rise2 = 0;
    int   mosi2_bad = 0;
    int   per2_bad = 0;
    logic sck2_prev = 1'b0;
    logic exp_mosi2 = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_leds_master #(.CLK_DIV(CD), .GAP(GP)) u_dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .start_i    (start),
        .tx_data_i  (tx_data),
        .busy_o     (busy),
        .done_o     (done),
        .rx_data_o  (rx_data),
`ifdef SPI_LEDS_MASTER_SIG_CHECK_EN
        .sig_err_o  (sig_err),
`endif
        .spi_sck_o  (sck),
        .spi_mosi_o (mosi),
        .spi_miso_i (miso),
        .spi_cs_o   (cs)
    );

    spi_leds_master #(.CLK_DIV(CD2), .GAP(GP)) u_dut2 (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .start_i    (start2),
        .tx_data_i  (tx2),
        .busy_o     (busy2),
        .done_o     (done2),
        .rx_data_o  (rx2),
`ifdef SPI_LEDS_MASTER_SIG_CHECK_EN
        .sig_err_o  (sig2),
`endif
        .spi_sck_o  (sck2),
        .spi_mosi_o (mosi2),
        .spi_miso_i (miso2),
        .spi_cs_o   (cs2)
    );

`ifndef SPI_LEDS_MASTER_SIG_CHECK_EN
    assign sig_err = 1'b0;
    assign sig2    = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slave: shifts its byte out MSB-first, new bit after every SCK fall.
    always @(negedge cs) begin
        slv_sh  = (slave_q.size() > 0) ? slave_q.pop_front() : 8'h00;
        miso    = slv_sh[7];
        rises   = 0;
        mosi_sh = '0;
    end

    always @(negedge sck) begin
        if (!cs) begin
            slv_sh = {slv_sh[6:0], 1'b0};
            miso   = slv_sh[7];
        end
    end

    always @(posedge sck) begin
        mosi_sh = {mosi_sh[6:0], mosi};
        rises++;
        rise_total++;
    end

    // Scoreboard monitor for the main instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (done) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_data", rx_data, e.rx);
                    check("mosi_bits", mosi_sh, e.tx);
                    check("sck_rises", rises, 8);
                    check("done_cycle", cyc, e.done_cyc);
                    check("cs_high_at_done", cs, 1'b1);
`ifdef SPI_LEDS_MASTER_SIG_CHECK_EN
                    check("sig_err", sig_err, e.sig);
`endif
                end
                last_done = cyc;
            end
            if (b2b && n_done > b2b_base && cs_prev && !cs)
                check("cs_gap_cycles", cyc - last_done, GP + 2);
        end
        cs_prev = cs;
    end

    // Second instance: MOSI constancy and SCK period.
    always @(negedge clk) begin
        if (!cs2 && mosi2 !== exp_mosi2) mosi2_bad++;
        if (sck2 && !sck2_prev) begin
            if (last_rise2 != 0 && (cyc - last_rise2) != 2 * CD2) per2_bad++;
            last_rise2 = cyc;
            rises2++;
        end
        sck2_prev = sck2;
    end

    task automatic push_exp(input logic [7:0] tx, input logic [7:0] sb, input int dc);
        exp_t e;
        e.tx       = tx;
        e.rx       = sb;
        e.sig      = (sb[7:4] != 4'hA);
        e.done_cyc = dc;
        exp_q.push_back(e);
        slave_q.push_back(sb);
        n_exp++;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("busy_timeout", busy, 1'b0);
    endtask

    task automatic run_xfer(input logic [7:0] tx, input logic [7:0] sb);
        wait_idle();
        @(negedge clk);
        tx_data = tx;
        start   = 1'b1;
        push_exp(tx, sb, cyc + 1 + XFER);
        @(negedge clk);
        start   = 1'b0;
        tx_data = 8'($urandom);
        wait_idle();
    endtask

    task automatic xfer2(input logic [7:0] tx, input logic miso_lvl, input logic [7:0] exp_rx);
        int c0;
        int n = 0;
        @(negedge clk);
        tx2        = tx;
        miso2      = miso_lvl;
        exp_mosi2  = tx[7];
        mosi2_bad  = 0;
        per2_bad   = 0;
        rises2     = 0;
        last_rise2 = 0;
        start2     = 1'b1;
        c0         = cyc;
        @(negedge clk);
        start2 = 1'b0;
        tx2    = ~tx;
        while (!done2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("d2_done_cycle", cyc, c0 + 1 + 17 * CD2);
        check("d2_rx", rx2, exp_rx);
        check("d2_mosi_const", mosi2_bad, 0);
        check("d2_sck_period", per2_bad, 0);
        check("d2_sck_rises", rises2, 8);
        n = 0;
        while (busy2 && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog timeout");
    end

    initial begin
        logic [7:0] t, m;
        int n, rb;
        rst_n   = 1'b0;
        start   = 1'b0;
        tx_data = '0;
        start2  = 1'b0;
        tx2     = '0;
        miso2   = 1'b0;
        miso    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cs", cs, 1'b1);
        check("rst_sck", sck, 1'b0);
        check("rst_mosi", mosi, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rx", rx_data, 8'h00);
        check("rst_sig", sig_err, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        run_xfer(8'h5A, 8'hA9);
        run_xfer(8'hC3, 8'h37);
        run_xfer(8'h0F, 8'hA0);
        for (int i = 0; i < 8; i++) begin
            t = 8'($urandom);
            m = ($urandom_range(1, 0) == 1) ? {4'hA, 4'($urandom)} : 8'($urandom);
            run_xfer(t, m);
        end

        // start pulsed mid-transfer must be dropped
        wait_idle();
        @(negedge clk);
        tx_data = 8'h81;
        start   = 1'b1;
        push_exp(8'h81, 8'hA4, cyc + 1 + XFER);
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        tx_data = 8'h7E;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (12) @(negedge clk);
        check("ignored_start_dones", n_done, n_exp);

        // start held: three back-to-back transfers
        @(negedge clk);
        b2b_base = n_done;
        b2b      = 1'b1;
        rb       = rise_total;
        tx_data  = 8'h96;
        start    = 1'b1;
        push_exp(8'h96, 8'hA5, cyc + 1 + XFER);
        push_exp(8'h96, 8'h3C, cyc + 1 + XFER + (GP + 2 + XFER));
        push_exp(8'h96, 8'hAF, cyc + 1 + XFER + 2 * (GP + 2 + XFER));
        n = 0;
        while (n_done < b2b_base + 3 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("b2b_done_count", n_done - b2b_base, 3);
        wait_idle();
        b2b = 1'b0;
        check("b2b_sck_rises", rise_total - rb, 24);

        // reset after the third SCK rise aborts cleanly
        @(negedge clk);
        slave_q.push_back(8'hA1);
        tx_data = 8'hE7;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (rises < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("pre_rst_rises", rises, 3);
        #1 rst_n = 1'b0;
        #1;
        check("abort_cs", cs, 1'b1);
        check("abort_sck", sck, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_rx", rx_data, 8'h00);
        check("abort_done", done, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        check("abort_no_done", n_done, n_exp);
        run_xfer(8'h3C, 8'hA6);

        xfer2(8'hFF, 1'b0, 8'h00);
        xfer2(8'h00, 1'b1, 8'hFF);

        repeat (5) @(negedge clk);
        check("exp_queue_empty", exp_q.size(), 0);
        check("total_dones", n_done, n_exp);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
